// File: rtl/regfile_wport_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wport_arbiter
//  Purpose  : Shares the register-file write port between the in-order WB
//             stage and the multi-cycle MDU. MDU results wait in a small FIFO
//             and drain into free write-port cycles. WB is stalled only for
//             starvation relief or to keep same-register writes in order.
//             Also flags decode-stage RAW hazards against queued results.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_wport_arbiter #(
    parameter int DEPTH      = 2,
    parameter int MAX_STREAK = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        WbWre,
    input  logic [4:0]  WbReg,
    input  logic [31:0] WbData,
    output logic        WbStall,
    input  logic        MduValid,
    input  logic [4:0]  MduReg,
    input  logic [31:0] MduData,
    output logic        MduReady,
    input  logic [4:0]  ReadReg1,
    input  logic [4:0]  ReadReg2,
    output logic        HazStall,
    output logic        RegWre,
    output logic [4:0]  WriteReg,
    output logic [31:0] WriteData
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(MAX_STREAK + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [SW-1:0] MAX_C   = SW'(MAX_STREAK);

    // FIFO storage and bookkeeping
    logic [4:0]    ent_reg_q  [DEPTH];
    logic [4:0]    ent_reg_d  [DEPTH];
    logic [31:0]   ent_data_q [DEPTH];
    logic [31:0]   ent_data_d [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic [SW-1:0] streak_q, streak_d;

    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] wb_match;
    logic [DEPTH-1:0] haz_match;

    logic wbreq;
    logic ne;
    logic order_hit;
    logic mdu_gnt;
    logic wb_gnt;
    logic push;

    // An entry is live when its distance from the read pointer is below count
    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_entry
            logic [PW-1:0] off;
            assign off          = PW'(i) - rd_ptr_q;
            assign valid[i]     = ({1'b0, off} < count_q);
            assign wb_match[i]  = valid[i] & (ent_reg_q[i] == WbReg);
            assign haz_match[i] = valid[i] &
                                  (((ent_reg_q[i] == ReadReg1) & (ReadReg1 != 5'd0)) |
                                   ((ent_reg_q[i] == ReadReg2) & (ReadReg2 != 5'd0)));
        end
    endgenerate

    // Per-cycle write-port arbitration and zero-latency write-port drive
    always_comb begin
        wbreq     = WbWre & (WbReg != 5'd0) & ~RST;
        ne        = (count_q != '0);
        order_hit = |wb_match;
        // Queue drains first when WB is idle, WB has hogged the port, or WB
        // would overwrite a register an older MDU result still targets.
        mdu_gnt   = ne & (~wbreq | (streak_q == MAX_C) | order_hit);
        wb_gnt    = wbreq & ~mdu_gnt;

        WbStall   = wbreq & mdu_gnt;
        MduReady  = (count_q < DEPTH_C);
        HazStall  = |haz_match;

        RegWre    = 1'b0;
        WriteReg  = 5'd0;
        WriteData = 32'd0;
        if (mdu_gnt) begin
            RegWre    = 1'b1;
            WriteReg  = ent_reg_q[rd_ptr_q];
            WriteData = ent_data_q[rd_ptr_q];
        end else if (wb_gnt) begin
            RegWre    = 1'b1;
            WriteReg  = WbReg;
            WriteData = WbData;
        end
    end

    // Next-state for FIFO contents, pointers, occupancy and WB streak
    always_comb begin
        // Writes to r0 are accepted on the handshake but dropped here
        push       = MduValid & MduReady & (MduReg != 5'd0);
        ent_reg_d  = ent_reg_q;
        ent_data_d = ent_data_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        if (push) begin
            ent_reg_d[wr_ptr_q]  = MduReg;
            ent_data_d[wr_ptr_q] = MduData;
            wr_ptr_d             = wr_ptr_q + PW'(1);
        end
        if (mdu_gnt) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case ({push, mdu_gnt})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (mdu_gnt || !ne) begin
            streak_d = '0;
        end else if (wb_gnt && (streak_q != MAX_C)) begin
            streak_d = streak_q + SW'(1);
        end else begin
            streak_d = streak_q;
        end
    end

    // State registers; async reset discards every queued result
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_reg_q[i]  <= 5'd0;
                ent_data_q[i] <= 32'd0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            streak_q <= '0;
        end else begin
            ent_reg_q  <= ent_reg_d;
            ent_data_q <= ent_data_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            streak_q   <= streak_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wport_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_wport_arbiter
//  Purpose  : Self-checking bench for regfile_wport_arbiter: directed
//             scenarios plus randomized traffic against a queue-based model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_regfile_wport_arbiter;

    localparam int DEPTH      = 2;
    localparam int MAX_STREAK = 4;

    logic        CLK, RST;
    logic        WbWre;
    logic [4:0]  WbReg;
    logic [31:0] WbData;
    logic        WbStall;
    logic        MduValid;
    logic [4:0]  MduReg;
    logic [31:0] MduData;
    logic        MduReady;
    logic [4:0]  ReadReg1, ReadReg2;
    logic        HazStall;
    logic        RegWre;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;

    int checks   = 0;
    int failures = 0;

    regfile_wport_arbiter #(.DEPTH(DEPTH), .MAX_STREAK(MAX_STREAK)) dut (
        .CLK(CLK), .RST(RST),
        .WbWre(WbWre), .WbReg(WbReg), .WbData(WbData), .WbStall(WbStall),
        .MduValid(MduValid), .MduReg(MduReg), .MduData(MduData), .MduReady(MduReady),
        .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .HazStall(HazStall),
        .RegWre(RegWre), .WriteReg(WriteReg), .WriteData(WriteData)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- behavioural reference model ----------------
    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    int          streak;
    logic [31:0] rf_dut [32];

    logic        exp_wre, exp_stall, exp_ready, exp_haz, m_mdu, m_wb, m_ne;
    logic [4:0]  exp_reg;
    logic [31:0] exp_data;

    function automatic void model_eval();
        logic wbreq, hit;
        wbreq = WbWre && (WbReg != 0);
        m_ne  = (q.size() > 0);
        hit   = 1'b0;
        exp_haz = 1'b0;
        foreach (q[i]) begin
            if (wbreq && q[i].r == WbReg) hit = 1'b1;
            if ((ReadReg1 != 0 && q[i].r == ReadReg1) ||
                (ReadReg2 != 0 && q[i].r == ReadReg2)) exp_haz = 1'b1;
        end
        m_mdu     = m_ne && (!wbreq || streak == MAX_STREAK || hit);
        m_wb      = wbreq && !m_mdu;
        exp_stall = wbreq && m_mdu;
        exp_ready = (q.size() < DEPTH);
        exp_wre   = m_mdu || m_wb;
        exp_reg   = m_mdu ? q[0].r : (m_wb ? WbReg : 5'd0);
        exp_data  = m_mdu ? q[0].d : (m_wb ? WbData : 32'd0);
    endfunction

    function automatic void model_commit();
        if (m_mdu) void'(q.pop_front());
        if (MduValid && exp_ready && MduReg != 0) q.push_back('{r: MduReg, d: MduData});
        if (m_mdu || !m_ne) streak = 0;
        else if (m_wb && streak < MAX_STREAK) streak++;
    endfunction

    function automatic void model_reset();
        q.delete();
        streak = 0;
    endfunction

    // Wait to mid-cycle, evaluate the model and record what the DUT writes
    task automatic settle();
        @(negedge CLK);
        model_eval();
        if (RegWre === 1'b1) rf_dut[WriteReg] = WriteData;
    endtask

    task automatic edge_step();
        @(posedge CLK);
        model_commit();
        #1;
    endtask

    task automatic idle_inputs();
        WbWre = 0; WbReg = 0; WbData = 0;
        MduValid = 0; MduReg = 0; MduData = 0;
        ReadReg1 = 0; ReadReg2 = 0;
    endtask

    task automatic drain();
        idle_inputs();
        for (int k = 0; k < 2 * DEPTH + 2; k++) begin
            settle();
            edge_step();
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        WbWre = 1; WbReg = 5'd9; WbData = 32'hDEAD;
        RST = 1;
        #3;
        checks++;
        if ({RegWre, WbStall, HazStall, MduReady} !== 4'b0001 || WriteReg !== 5'd0 || WriteData !== 32'd0) begin
            failures++;
            $display("FAIL reset_state: wre/stall/haz/rdy=%b%b%b%b reg=%0d data=%h required 0001 reg=0 data=0",
                     RegWre, WbStall, HazStall, MduReady, WriteReg, WriteData);
        end
        @(posedge CLK); #1;
        RST = 0;
        model_reset();
        idle_inputs();
    endtask

    task automatic test_mdu_only();
        MduValid = 1; MduReg = 5'd5; MduData = 32'h1234;
        settle();
        checks++;
        if (RegWre !== 1'b0 || MduReady !== 1'b1) begin
            failures++;
            $display("FAIL mdu_only_c0: wre=%b rdy=%b required wre=0 rdy=1", RegWre, MduReady);
        end
        edge_step();
        MduValid = 0;
        settle();
        checks++;
        if (RegWre !== 1'b1 || WriteReg !== 5'd5 || WriteData !== 32'h1234) begin
            failures++;
            $display("FAIL mdu_only_c1: wre=%b reg=%0d data=%h required 1 5 00001234", RegWre, WriteReg, WriteData);
        end
        edge_step();
        settle();
        checks++;
        if (RegWre !== 1'b0) begin
            failures++;
            $display("FAIL mdu_only_c2: wre=%b required 0", RegWre);
        end
        edge_step();
    endtask

    task automatic test_starvation();
        int grants = 0;
        int nreg   = 1;
        bit seen   = 0;
        MduValid = 1; MduReg = 5'd7; MduData = 32'h77;
        edge_step();
        MduValid = 0;
        for (int k = 0; k < 12 && !seen; k++) begin
            WbWre = 1; WbReg = 5'(nreg); WbData = 32'h100 + nreg;
            settle();
            checks++;
            if (WbStall !== exp_stall || WriteReg !== exp_reg) begin
                failures++;
                $display("FAIL starve_cycle: stall=%b reg=%0d required stall=%b reg=%0d", WbStall, WriteReg, exp_stall, exp_reg);
            end
            if (WbStall === 1'b1) begin
                seen = 1;
                checks++;
                if (grants !== MAX_STREAK || WriteReg !== 5'd7 || WriteData !== 32'h77) begin
                    failures++;
                    $display("FAIL starve_streak: grants=%0d reg=%0d data=%h required %0d 7 00000077",
                             grants, WriteReg, WriteData, MAX_STREAK);
                end
            end else if (RegWre === 1'b1 && WriteReg === WbReg) begin
                grants++;
                nreg++;
            end
            edge_step();
        end
        if (!seen) begin
            failures++;
            $display("FAIL starve_timeout: no WbStall within bound, grants=%0d required stall after %0d", grants, MAX_STREAK);
        end
        settle();
        checks++;
        if (WbStall !== 1'b0 || RegWre !== 1'b1 || WriteReg !== 5'd5 || WriteData !== 32'h105) begin
            failures++;
            $display("FAIL starve_resume: stall=%b wre=%b reg=%0d data=%h required 0 1 5 00000105",
                     WbStall, RegWre, WriteReg, WriteData);
        end
        edge_step();
        idle_inputs();
    endtask

    task automatic test_ordering();
        MduValid = 1; MduReg = 5'd3; MduData = 32'hA;
        edge_step();
        MduValid = 0;
        WbWre = 1; WbReg = 5'd3; WbData = 32'hB;
        settle();
        checks++;
        if (WbStall !== 1'b1 || RegWre !== 1'b1 || WriteReg !== 5'd3 || WriteData !== 32'hA) begin
            failures++;
            $display("FAIL order_first: stall=%b wre=%b reg=%0d data=%h required 1 1 3 0000000a",
                     WbStall, RegWre, WriteReg, WriteData);
        end
        edge_step();
        settle();
        checks++;
        if (WbStall !== 1'b0 || RegWre !== 1'b1 || WriteData !== 32'hB) begin
            failures++;
            $display("FAIL order_second: stall=%b wre=%b data=%h required 0 1 0000000b", WbStall, RegWre, WriteData);
        end
        edge_step();
        idle_inputs();
        checks++;
        if (rf_dut[3] !== 32'hB) begin
            failures++;
            $display("FAIL order_final: r3=%h required 0000000b", rf_dut[3]);
        end
    endtask

    task automatic test_full_zero();
        int waited = 0;
        WbWre = 1; WbReg = 5'd10; WbData = 32'h10;
        MduValid = 1; MduReg = 5'd20; MduData = 32'h20;
        edge_step();
        WbReg = 5'd11; MduReg = 5'd21; MduData = 32'h21;
        settle();
        checks++;
        if (MduReady !== 1'b1 || WbStall !== 1'b0) begin
            failures++;
            $display("FAIL full_second: rdy=%b stall=%b required 1 0", MduReady, WbStall);
        end
        edge_step();
        WbReg = 5'd12; MduReg = 5'd22; MduData = 32'h22;
        settle();
        checks++;
        if (MduReady !== 1'b0) begin
            failures++;
            $display("FAIL full_ready: rdy=%b required 0", MduReady);
        end
        edge_step();
        WbWre = 0;
        settle();
        checks++;
        if (MduReady !== 1'b0 || RegWre !== 1'b1 || WriteReg !== 5'd20) begin
            failures++;
            $display("FAIL full_no_push_through: rdy=%b wre=%b reg=%0d required 0 1 20", MduReady, RegWre, WriteReg);
        end
        edge_step();
        while (waited < 6) begin
            settle();
            if (MduReady === 1'b1) break;
            edge_step();
            waited++;
        end
        checks++;
        if (waited >= 6 || MduReady !== 1'b1) begin
            failures++;
            $display("FAIL full_third_accept: rdy=%b after %0d cycles required 1", MduReady, waited);
        end
        edge_step();
        drain();
        // r0 push: handshake completes but nothing is queued
        MduValid = 1; MduReg = 5'd0; MduData = 32'hFFFF;
        settle();
        checks++;
        if (MduReady !== 1'b1) begin
            failures++;
            $display("FAIL zero_ready: rdy=%b required 1", MduReady);
        end
        edge_step();
        idle_inputs();
        settle();
        checks++;
        if (RegWre !== 1'b0 || MduReady !== 1'b1 || HazStall !== 1'b0) begin
            failures++;
            $display("FAIL zero_discard: wre=%b rdy=%b haz=%b required 0 1 0", RegWre, MduReady, HazStall);
        end
        edge_step();
        WbWre = 1; WbReg = 5'd0; WbData = 32'h55;
        settle();
        checks++;
        if (RegWre !== 1'b0 || WbStall !== 1'b0) begin
            failures++;
            $display("FAIL zero_wb: wre=%b stall=%b required 0 0", RegWre, WbStall);
        end
        edge_step();
        idle_inputs();
    endtask

    task automatic test_hazard();
        WbWre = 1; WbReg = 5'd10; WbData = 32'h1;
        MduValid = 1; MduReg = 5'd4; MduData = 32'h44;
        edge_step();
        MduValid = 0;
        WbReg = 5'd11; ReadReg1 = 5'd4; ReadReg2 = 5'd0;
        settle();
        checks++;
        if (HazStall !== 1'b1) begin
            failures++;
            $display("FAIL haz_rs1: haz=%b required 1", HazStall);
        end
        #1 ReadReg1 = 5'd0; ReadReg2 = 5'd0; #1;
        checks++;
        if (HazStall !== 1'b0) begin
            failures++;
            $display("FAIL haz_zero: haz=%b required 0", HazStall);
        end
        #1 ReadReg2 = 5'd4; #1;
        checks++;
        if (HazStall !== 1'b1) begin
            failures++;
            $display("FAIL haz_rs2: haz=%b required 1", HazStall);
        end
        edge_step();
        WbWre = 0;
        settle();
        checks++;
        if (HazStall !== 1'b1 || RegWre !== 1'b1 || WriteReg !== 5'd4) begin
            failures++;
            $display("FAIL haz_popping: haz=%b wre=%b reg=%0d required 1 1 4", HazStall, RegWre, WriteReg);
        end
        edge_step();
        ReadReg1 = 5'd4;
        settle();
        checks++;
        if (HazStall !== 1'b0) begin
            failures++;
            $display("FAIL haz_drained: haz=%b required 0", HazStall);
        end
        edge_step();
        idle_inputs();
    endtask

    task automatic test_reset_mid_drain();
        WbWre = 1; WbReg = 5'd1; WbData = 32'h1;
        MduValid = 1; MduReg = 5'd8; MduData = 32'h88;
        edge_step();
        WbReg = 5'd2; MduReg = 5'd9; MduData = 32'h99;
        edge_step();
        idle_inputs();
        ReadReg1 = 5'd8;
        #2;
        RST = 1;
        #1;
        checks++;
        if (RegWre !== 1'b0 || MduReady !== 1'b1 || HazStall !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: wre=%b rdy=%b haz=%b required 0 1 0", RegWre, MduReady, HazStall);
        end
        model_reset();
        @(posedge CLK); #1;
        RST = 0;
        for (int k = 0; k < 5; k++) begin
            settle();
            checks++;
            if (RegWre !== 1'b0 || exp_wre !== 1'b0) begin
                failures++;
                $display("FAIL reset_discard: wre=%b reg=%0d required wre=0", RegWre, WriteReg);
            end
            edge_step();
        end
        idle_inputs();
    endtask

    task automatic test_random();
        bit wb_pend  = 0;
        bit mdu_pend = 0;
        for (int k = 0; k < 400; k++) begin
            if (!wb_pend) begin
                WbWre  = ($urandom_range(0, 99) < 70);
                WbReg  = 5'($urandom_range(0, 7));
                WbData = $urandom;
            end
            if (!mdu_pend) begin
                MduValid = ($urandom_range(0, 99) < 40);
                MduReg   = 5'($urandom_range(0, 7));
                MduData  = $urandom;
            end
            ReadReg1 = 5'($urandom_range(0, 7));
            ReadReg2 = 5'($urandom_range(0, 7));
            settle();
            checks++;
            if (RegWre !== exp_wre || WriteReg !== exp_reg || WriteData !== exp_data) begin
                failures++;
                $display("FAIL rand_write[%0d]: wre=%b reg=%0d data=%h required %b %0d %h",
                         k, RegWre, WriteReg, WriteData, exp_wre, exp_reg, exp_data);
            end
            checks++;
            if (WbStall !== exp_stall) begin
                failures++;
                $display("FAIL rand_stall[%0d]: stall=%b required %b", k, WbStall, exp_stall);
            end
            checks++;
            if (MduReady !== exp_ready || HazStall !== exp_haz) begin
                failures++;
                $display("FAIL rand_rdy_haz[%0d]: rdy=%b haz=%b required %b %b", k, MduReady, HazStall, exp_ready, exp_haz);
            end
            wb_pend  = exp_stall;
            mdu_pend = MduValid && !exp_ready;
            edge_step();
        end
        drain();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf_dut[i] = 32'd0;
        model_reset();
        test_reset();
        test_mdu_only();
        drain();
        test_starvation();
        drain();
        test_ordering();
        drain();
        test_full_zero();
        drain();
        test_hazard();
        drain();
        test_reset_mid_drain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time bound, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
